// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-requester front end that sequences fixed-length
// read/write operations into the single-port SRAM controller.
module sram_arbiter #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 16,
  parameter int OP_CYCLES  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rvalid,
  output logic                  m0_done,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rvalid,
  output logic                  m1_done,
  output logic                  sram_write_tick,
  output logic                  sram_read_tick,
  output logic [ADDR_WIDTH-1:0] sram_addr_in,
  output logic [DATA_WIDTH-1:0] sram_data_in,
  input  logic [DATA_WIDTH-1:0] sram_data_out,
  output logic                  busy
);
  localparam int CW = $clog2(OP_CYCLES + 1);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic last_owner, owner, we_r, sel, any_req, last_cyc;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  // On contention the requester that did not win last time is chosen.
  assign any_req  = m0_req | m1_req;
  assign sel      = (m0_req & m1_req) ? ~last_owner : m1_req;
  assign last_cyc = cnt == CW'(OP_CYCLES - 1);
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = any_req ? S_ISSUE : S_IDLE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  state_nx = last_cyc ? S_DONE : S_WAIT;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last_owner <= 1'b1;
      owner      <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && any_req) begin
        owner      <= sel;
        last_owner <= sel;
        we_r       <= sel ? m1_we : m0_we;
        addr_r     <= sel ? m1_addr : m0_addr;
        wdata_r    <= sel ? m1_wdata : m0_wdata;
      end
      if (state == S_ISSUE) cnt <= CW'(1);
      if (state == S_WAIT) cnt <= cnt + CW'(1);
      if (state == S_WAIT && last_cyc && !we_r && !owner) m0_rdata <= sram_data_out;
      if (state == S_WAIT && last_cyc && !we_r && owner) m1_rdata <= sram_data_out;
    end
  end
  assign m0_gnt          = state == S_ISSUE && !owner;
  assign m1_gnt          = state == S_ISSUE && owner;
  assign sram_write_tick = state == S_ISSUE && we_r;
  assign sram_read_tick  = state == S_ISSUE && !we_r;
  assign m0_done         = state == S_DONE && !owner;
  assign m1_done         = state == S_DONE && owner;
  assign m0_rvalid       = m0_done && !we_r;
  assign m1_rvalid       = m1_done && !we_r;
  assign sram_addr_in    = addr_r;
  assign sram_data_in    = wdata_r;
  assign busy            = state != S_IDLE;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of sram_arbiter against a small behavioural SRAM.
module tb_sram_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [18:0] m0_addr = 0, m1_addr = 0;
  logic [15:0] m0_wdata = 0, m1_wdata = 0;
  logic        m0_gnt, m0_rvalid, m0_done, m1_gnt, m1_rvalid, m1_done;
  logic [15:0] m0_rdata, m1_rdata;
  logic        sram_write_tick, sram_read_tick, busy;
  logic [18:0] sram_addr_in;
  logic [15:0] sram_data_in, sram_data_out;
  logic [15:0] mem [256];
  int tests = 0, failed = 0, cyc_n = 0;

  sram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_done(m0_done),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_done(m1_done),
    .sram_write_tick(sram_write_tick), .sram_read_tick(sram_read_tick),
    .sram_addr_in(sram_addr_in), .sram_data_in(sram_data_in),
    .sram_data_out(sram_data_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  always @(posedge clk) if (sram_write_tick) mem[sram_addr_in[7:0]] <= sram_data_in;
  assign sram_data_out = mem[sram_addr_in[7:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit who, input bit req, input bit we, input logic [18:0] a, input logic [15:0] d);
    if (who) begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; end
    else begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; end
  endtask

  // One full operation: grant at T, ticks only at T, stable address, done at T+5.
  task automatic op(input bit who, input bit we, input logic [18:0] a, input logic [15:0] d, input logic [15:0] exp_rd);
    int n = 0;
    drive(who, 1, we, a, d);
    @(negedge clk);
    while (!(who ? m1_gnt : m0_gnt) && n < 20) begin @(negedge clk); n++; end
    check("gnt", who ? m1_gnt : m0_gnt, 1);
    check("other_gnt", who ? m0_gnt : m1_gnt, 0);
    check("tick_T", {sram_write_tick, sram_read_tick}, we ? 2'b10 : 2'b01);
    drive(who, 0, ~we, ~a, ~d);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("no_tick", {sram_write_tick, sram_read_tick, m0_gnt, m1_gnt}, 0);
      check("addr_hold", sram_addr_in, a);
      if (k == 3 && we) check("data_in_T3", sram_data_in, d);
    end
    @(negedge clk);
    check("done", who ? m1_done : m0_done, 1);
    check("rvalid", who ? m1_rvalid : m0_rvalid, !we);
    check("other_done", who ? {m0_done, m0_rvalid} : {m1_done, m1_rvalid}, 0);
    check("addr_T5", sram_addr_in, a);
    if (!we) check("rdata", who ? m1_rdata : m0_rdata, exp_rd);
    @(negedge clk);
    check("done_pulse", {m0_done, m1_done, m0_rvalid, m1_rvalid, busy}, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  // Holds the given requests and checks owner order and 7-cycle tick spacing.
  task automatic stream(input bit both);
    int n, prev = 0;
    drive(0, 1, 0, 19'h10, 0);
    if (both) drive(1, 1, 0, 19'h11, 0);
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!(m0_gnt | m1_gnt) && n < 20) begin @(negedge clk); n++; end
      check("stream_owner", {m1_gnt, m0_gnt}, (both && i % 2 == 1) ? 2'b10 : 2'b01);
      check("stream_tick", sram_read_tick, 1);
      if (i > 0) check("tick_gap", cyc_n - prev, 7);
      prev = cyc_n;
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int n, ticks;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h10] = 16'hA5A5;
    @(negedge clk);
    check("rst_outs", {m0_gnt, m1_gnt, m0_done, m1_done, m0_rvalid, m1_rvalid, sram_write_tick, sram_read_tick, busy}, 0);
    check("rst_rdata", {m0_rdata, m1_rdata}, 0);
    check("rst_addr", sram_addr_in, 0);
    rst_n = 1;
    op(0, 0, 19'h00010, 16'h0, 16'hA5A5);
    check("m1_untouched", {m1_rdata, 3'(m1_done), 3'(m1_rvalid)}, 0);
    op(1, 1, 19'h7FFFF, 16'h1234, 16'h0);
    op(1, 1, 19'h00123, 16'hBEEF, 16'h0);
    op(0, 0, 19'h00123, 16'h0, 16'hBEEF);
    check("m1_rdata_kept", m1_rdata, 0);
    do_reset();
    stream(1);
    stream(0);
    drive(1, 1, 1, 19'h00042, 16'h5555);
    n = 0;
    while (!m1_gnt && n < 20) begin @(negedge clk); n++; end
    check("rst_mid_gnt", m1_gnt, 1);
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("rst_mid_outs", {busy, m1_done, sram_write_tick, sram_read_tick}, 0);
    check("rst_mid_bus", {sram_addr_in, sram_data_in}, 0);
    @(negedge clk);
    rst_n = 1;
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ticks += int'(sram_write_tick | sram_read_tick | m1_done);
    end
    check("rst_mid_no_tick", ticks, 0);
    op(0, 0, 19'h00010, 16'h0, 16'hA5A5);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
